// File: rtl/mano_pkg.sv
// Shared definitions for the basic-computer memory datapath blocks.
//   - OP_AND..OP_IO : 3-bit opcode values (IR[14:12])
//   - T0..T7        : sequence-counter values
//   - dec3to8       : 3-to-8 one-hot decoder, also used by the memory and ALU blocks
//   - seq_state_e   : memory-port ownership state (CPU or program loader)
package mano_pkg;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_IO  = 3'd7;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;
    localparam logic [2:0] T5 = 3'd5;
    localparam logic [2:0] T6 = 3'd6;
    localparam logic [2:0] T7 = 3'd7;

    typedef enum logic {
        CPU    = 1'b0,
        LOADER = 1'b1
    } seq_state_e;

    function automatic logic [7:0] dec3to8(input logic [2:0] sel);
        logic [7:0] res;
        res = 8'h00;
        res[sel] = 1'b1;
        return res;
    endfunction

endpackage

// File: rtl/mano_mem_sequencer_if.sv
// Memory-port bundle between the sequencer, the memory and the program loader.
//   LD_REQ / LD_WE / LD_ADDR : loader request, write strobe and address
//   LD_GNT                   : loader owns the memory port
//   MEM_SEL                  : 0 = CPU drives address/data, 1 = loader drives them
//   MEM_RD / MEM_WR          : memory strobes (never both high)
//   MEM_ADDR                 : loader address while MEM_SEL=1, else 0
//
// Request/grant semantics: the loader raises LD_REQ and holds it for as long
// as it wants the port. LD_GNT rises one cycle after the request is seen at an
// instruction boundary (SC=0) and stays high while LD_REQ stays high. LD_WE is
// only honoured while LD_GNT=1. Dropping LD_REQ releases the port at the next
// clock edge.
interface mano_mem_sequencer_if #(
    parameter int AW = 12
);
    logic          LD_REQ;
    logic          LD_WE;
    logic [AW-1:0] LD_ADDR;
    logic          LD_GNT;
    logic          MEM_SEL;
    logic          MEM_RD;
    logic          MEM_WR;
    logic [AW-1:0] MEM_ADDR;

    // Sequencer side.
    modport master (
        input  LD_REQ, LD_WE, LD_ADDR,
        output LD_GNT, MEM_SEL, MEM_RD, MEM_WR, MEM_ADDR
    );

    // Loader / memory side.
    modport slave (
        output LD_REQ, LD_WE, LD_ADDR,
        input  LD_GNT, MEM_SEL, MEM_RD, MEM_WR, MEM_ADDR
    );
endinterface

// File: rtl/mano_seq_counter.sv
// 3-bit sequence counter with one-hot timing decode.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force SC to 0 at the next edge (has priority over inc)
//   inc        : advance SC by one at the next edge
//   sc         : current count
//   t          : one-hot timing signal T0..T7
module mano_seq_counter
    import mano_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [2:0] sc,
    output logic [7:0] t
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc <= T0;
        end else if (clr) begin
            sc <= T0;
        end else if (inc) begin
            sc <= sc + 3'd1;
        end
    end

    assign t = dec3to8(sc);

endmodule

// File: rtl/mano_mem_sequencer.sv
// Timing and control sequencer for the basic-computer memory datapath.
// Owns the sequence counter, latches opcode/indirect bit at T2, and decodes
// per-cycle memory strobes and register micro-ops for fetch, indirect and
// memory-reference execution. Hands the memory port to a program loader
// only at instruction boundaries.
//   CLK, RST_N   : clock, asynchronous active-low reset
//   RUN          : 1 = fetch at T0, 0 = park at T0 (sampled at T0 only)
//   IR_IN        : instruction register, sampled at T2
//   DR_ZERO      : ISZ skip test, used at T6
//   mem          : memory/loader port bundle (master side)
//   T, D, I_BIT  : one-hot timing, one-hot latched opcode, latched indirect bit
//   AR_LD_PC..DR_INC : datapath micro-op enables
//   SC_CLR       : sequence counter clears at the next edge
//   state_dbg    : current port-ownership state
module mano_mem_sequencer
    import mano_pkg::*;
#(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 RUN,
    input  logic [DW-1:0]        IR_IN,
    input  logic                 DR_ZERO,
    mano_mem_sequencer_if.master mem,
    output logic [7:0]           T,
    output logic [7:0]           D,
    output logic                 I_BIT,
    output logic                 AR_LD_PC,
    output logic                 IR_LD,
    output logic                 PC_INC,
    output logic                 AR_LD_IR,
    output logic                 AR_LD_MEM,
    output logic                 DR_LD,
    output logic                 AC_OP,
    output logic                 AR_INC,
    output logic                 PC_LD,
    output logic                 DR_INC,
    output logic                 SC_CLR,
    output seq_state_e           state_dbg
);

    seq_state_e    state, state_next;
    logic [2:0]    sc;
    logic          sc_inc;
    logic          force_clr;   // silent clear: illegal step or loader hold
    logic          latch_ir;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] loader_addr;
    logic          is_mri_load;

    // Only the opcode and indirect bit matter here; the address field
    // belongs to the AR path.
    logic unused_ir_bits;
    assign unused_ir_bits = ^IR_IN[DW-5:0];

    mano_seq_counter u_sc (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (SC_CLR | force_clr),
        .inc   (sc_inc),
        .sc    (sc),
        .t     (T)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= CPU;
            D     <= 8'h00;
            I_BIT <= 1'b0;
        end else begin
            state <= state_next;
            if (latch_ir) begin
                D     <= dec3to8(IR_IN[DW-2:DW-4]);
                I_BIT <= IR_IN[DW-1];
            end
        end
    end

    assign is_mri_load = D[OP_AND] | D[OP_ADD] | D[OP_LDA];

    always_comb begin
        state_next = state;
        sc_inc     = 1'b0;
        force_clr  = 1'b0;
        latch_ir   = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        AR_LD_PC   = 1'b0;
        IR_LD      = 1'b0;
        PC_INC     = 1'b0;
        AR_LD_IR   = 1'b0;
        AR_LD_MEM  = 1'b0;
        DR_LD      = 1'b0;
        AC_OP      = 1'b0;
        AR_INC     = 1'b0;
        PC_LD      = 1'b0;
        DR_INC     = 1'b0;
        SC_CLR     = 1'b0;

        case (state)
            CPU: begin
                case (sc)
                    T0: begin
                        // Loader request wins over RUN at a boundary.
                        if (mem.LD_REQ) begin
                            state_next = LOADER;
                        end else if (RUN) begin
                            AR_LD_PC = 1'b1;
                            sc_inc   = 1'b1;
                        end
                    end
                    T1: begin
                        mem_rd = 1'b1;
                        IR_LD  = 1'b1;
                        PC_INC = 1'b1;
                        sc_inc = 1'b1;
                    end
                    T2: begin
                        AR_LD_IR = 1'b1;
                        latch_ir = 1'b1;
                        sc_inc   = 1'b1;
                    end
                    T3: begin
                        if (D[OP_IO]) begin
                            SC_CLR = 1'b1;
                        end else begin
                            if (I_BIT) begin
                                mem_rd    = 1'b1;
                                AR_LD_MEM = 1'b1;
                            end
                            sc_inc = 1'b1;
                        end
                    end
                    T4: begin
                        if (is_mri_load || D[OP_ISZ]) begin
                            mem_rd = 1'b1;
                            DR_LD  = 1'b1;
                            sc_inc = 1'b1;
                        end else if (D[OP_STA]) begin
                            mem_wr = 1'b1;
                            SC_CLR = 1'b1;
                        end else if (D[OP_BUN]) begin
                            PC_LD  = 1'b1;
                            SC_CLR = 1'b1;
                        end else if (D[OP_BSA]) begin
                            mem_wr = 1'b1;
                            AR_INC = 1'b1;
                            sc_inc = 1'b1;
                        end else begin
                            force_clr = 1'b1;
                        end
                    end
                    T5: begin
                        if (is_mri_load) begin
                            AC_OP  = 1'b1;
                            SC_CLR = 1'b1;
                        end else if (D[OP_BSA]) begin
                            PC_LD  = 1'b1;
                            SC_CLR = 1'b1;
                        end else if (D[OP_ISZ]) begin
                            DR_INC = 1'b1;
                            sc_inc = 1'b1;
                        end else begin
                            force_clr = 1'b1;
                        end
                    end
                    T6: begin
                        if (D[OP_ISZ]) begin
                            mem_wr = 1'b1;
                            PC_INC = DR_ZERO;
                            SC_CLR = 1'b1;
                        end else begin
                            force_clr = 1'b1;
                        end
                    end
                    default: begin
                        // T7 is never part of a legal sequence.
                        force_clr = 1'b1;
                    end
                endcase
            end
            LOADER: begin
                force_clr = 1'b1;
                mem_wr    = mem.LD_WE;
                if (!mem.LD_REQ) begin
                    state_next = CPU;
                end
            end
        endcase
    end

    assign loader_addr  = mem.LD_ADDR;
    assign mem.LD_GNT   = (state == LOADER);
    assign mem.MEM_SEL  = (state == LOADER);
    assign mem.MEM_RD   = mem_rd;
    assign mem.MEM_WR   = mem_wr;
    assign mem.MEM_ADDR = (state == LOADER) ? loader_addr : '0;
    assign state_dbg    = state;

endmodule

// File: doc/mano_mem_sequencer.md
Name: mano_mem_sequencer

Overview:
Timing and control sequencer for the basic-computer memory datapath. It owns the 3-bit sequence counter, decodes the opcode and indirect bit from IR, and emits per-cycle memory read/write strobes and register-load controls for fetch, indirect, and memory-reference execution. It also arbitrates the memory port between the CPU and an external program-loader requester, granting the loader only at instruction boundaries.

Parameters:
AW, 12, memory address width (drives LD_ADDR/MEM_ADDR width)
DW, 16, data and instruction width

Ports:
CLK  in  1  system clock; all state updates on posedge
RST_N  in  1  asynchronous active-low reset
RUN  in  1  start/stop flag; 0 parks the sequencer at T0 with no fetch
IR_IN  in  DW  instruction register contents; valid from T2 onward
DR_ZERO  in  1  DR==0 after increment (ISZ skip test)
LD_REQ  in  1  loader requests the memory port
LD_WE  in  1  loader write strobe, honoured only while LD_GNT=1
LD_ADDR  in  AW  loader address
LD_GNT  out  1  loader owns the memory port
MEM_SEL  out  1  0: memory address/data from CPU (AR/bus); 1: from loader
MEM_RD  out  1  memory read strobe
MEM_WR  out  1  memory write strobe
MEM_ADDR  out  AW  LD_ADDR when MEM_SEL=1, else 0 (CPU path uses AR)
T  out  8  one-hot timing signal T0..T7
D  out  8  one-hot latched opcode D0..D7
I_BIT  out  1  latched IR[15]
AR_LD_PC, IR_LD, PC_INC, AR_LD_IR, AR_LD_MEM, DR_LD, AC_OP, AR_INC, PC_LD, DR_INC  out  1 each  datapath micro-operation enables
SC_CLR  out  1  sequence counter clears at next edge

Behaviour:
- Reset (async, RST_N=0): SC=0, D=8'h00, I_BIT=0, state=CPU, LD_GNT=0, MEM_SEL=0. All strobes are combinational from registered state, so they read 0 except T=8'h01.
- States: CPU, LOADER. Registered state comprises SC[2:0], D, I_BIT, and the state bit. All outputs are combinational decodes, stable for the full cycle.
- CPU -> LOADER: at a posedge where SC=0 and LD_REQ=1. LD_REQ takes priority over RUN. LD_GNT and MEM_SEL rise the following cycle.
- LOADER: SC is held at 0 and all CPU micro-ops are 0. MEM_RD=0, MEM_WR=LD_WE, MEM_ADDR=LD_ADDR.
- LOADER -> CPU: at the first posedge with LD_REQ=0. LD_GNT drops that edge, and fetch resumes at T0 in the next cycle if RUN=1.
- LD_REQ asserted mid-instruction: ignored until SC returns to 0. The current instruction always completes.
- RUN=0 at T0: SC stays 0 with no strobes. RUN is sampled only at T0.
- Micro-op sequence in CPU state with RUN=1:
  - T0: AR_LD_PC.
  - T1: MEM_RD, IR_LD, PC_INC.
  - T2: AR_LD_IR. D and I_BIT latch from IR_IN[14:12] and IR_IN[15] on this edge.
  - T3: if D7, SC_CLR (register/IO execution is external). Else if I_BIT, MEM_RD and AR_LD_MEM. Else no-op.
  - AND/ADD/LDA (D0/D1/D2): T4 MEM_RD, DR_LD. T5 AC_OP, SC_CLR.
  - STA (D3): T4 MEM_WR, SC_CLR.
  - BUN (D4): T4 PC_LD, SC_CLR.
  - BSA (D5): T4 MEM_WR, AR_INC. T5 PC_LD, SC_CLR.
  - ISZ (D6): T4 MEM_RD, DR_LD. T5 DR_INC. T6 MEM_WR, PC_INC if DR_ZERO, SC_CLR.
- SC increments each cycle unless SC_CLR is asserted or the sequencer is parked. Reaching T7 is illegal: force SC to 0 and assert no strobes.
- D/I_BIT hold from T2 until the next T2. IR_IN changes outside T2 have no effect.
- MEM_RD and MEM_WR are never both 1. At most one memory strobe is active per cycle.
- Reset mid-instruction: immediate return to the reset state. A write strobe drops asynchronously.

Decomposition:
- Shared package mano_pkg holds:
  - opcode constants OP_AND..OP_IO (3-bit)
  - timing index constants T0..T7
  - one-hot decode function dec3to8, reused by the existing memory and ALU blocks
  - state enum {CPU, LOADER}
- One sub-module, mano_seq_counter: 3-bit counter with CLR, INC and async active-low reset, exporting the one-hot T.

Test Plan:
- Reset then RUN=1, IR_IN=16'h2005 (LDA direct): MEM_RD at T1 and T4, DR_LD at T4, AC_OP and SC_CLR at T5; T returns to 8'h01 after 6 cycles.
- IR_IN=16'hB010 (STA indirect): MEM_RD and AR_LD_MEM at T3, MEM_WR at T4; total 5 cycles.
- IR_IN=16'h6020 (ISZ) with DR_ZERO=1 at T6: PC_INC and MEM_WR both at T6. Rerun with DR_ZERO=0: no PC_INC at T6.
- LD_REQ raised at T2 of a BSA: instruction completes (MEM_WR at T4, PC_LD at T5), then LD_GNT=1 one cycle after T0. LD_WE=1 with LD_ADDR=12'h0A0 gives MEM_WR=1, MEM_ADDR=12'h0A0, MEM_SEL=1.
- LD_REQ dropped: LD_GNT=0 next edge, then T0 fetch resumes with AR_LD_PC=1.
- RST_N pulled low during T4 of STA: MEM_WR falls immediately and T=8'h01, D=0, LD_GNT=0 while reset is held.
